// File: rtl/bit_wise_pipe.sv
// Op-selectable bitwise unit behind a STAGES-deep valid/ready pipeline with bubble collapsing.
// Define BIT_WISE_PIPE_STATS_EN to build the output-handshake counter on out_count.
module bit_wise_pipe #(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_c,
  output logic [2:0]   out_op,
  output logic         out_zero,
  output logic [31:0]  out_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_NOT  = 3'b111
  } op_e;

  logic [N-1:0]      fn;
  logic              fn_zero;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [N-1:0]      c_q  [STAGES];
  logic [2:0]        op_q [STAGES];
  logic [STAGES-1:0] z_q;

  always_comb begin
    fn = '0;
    case (op_e'(in_op))
      OP_AND:  fn = in_a & in_b;
      OP_OR:   fn = in_a | in_b;
      OP_XOR:  fn = in_a ^ in_b;
      OP_NAND: fn = ~(in_a & in_b);
      OP_NOR:  fn = ~(in_a | in_b);
      OP_XNOR: fn = ~(in_a ^ in_b);
      OP_ANDN: fn = in_a & ~in_b;
      default: fn = ~in_a;
    endcase
  end

  assign fn_zero = (fn == '0);

  // Unrolled ready chain: a stage can move if the sink is ready or any stage at or below it is empty.
  for (genvar g = 0; g < STAGES; g++) begin : g_rdy
    assign rdy[g] = out_ready | ~(&v[STAGES-1:g]);
  end

  assign in_ready = rdy[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v   <= '0;
      z_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        c_q[i]  <= '0;
        op_q[i] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        v[0] <= in_valid;
        // Data only moves with a valid beat, so idle-cycle X on the operands never enters the pipe.
        if (in_valid) begin
          c_q[0]  <= fn;
          op_q[0] <= in_op;
          z_q[0]  <= fn_zero;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            c_q[i]  <= c_q[i-1];
            op_q[i] <= op_q[i-1];
            z_q[i]  <= z_q[i-1];
          end
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_c     = c_q[STAGES-1];
  assign out_op    = op_q[STAGES-1];
  assign out_zero  = z_q[STAGES-1];

`ifdef BIT_WISE_PIPE_STATS_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (out_valid && out_ready) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign out_count = count_q;
`else
  assign out_count = 32'h0;
`endif

endmodule

// File: tb/tb_bit_wise_pipe.sv
// Directed bench: 32-bit/2-stage instance for function, stall, zero, reset and counter; 8-bit/4-stage instance for latency and random traffic.
module tb_bit_wise_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
  logic [2:0]  a_in_op, a_out_op;
  logic [31:0] a_in_a, a_in_b, a_out_c, a_out_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
  logic [2:0]  b_in_op, b_out_op;
  logic [7:0]  b_in_a, b_in_b, b_out_c;
  logic [31:0] b_out_count;

  bit_wise_pipe #(.N(32), .STAGES(2)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_a(a_in_a), .in_b(a_in_b),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_c(a_out_c), .out_op(a_out_op),
    .out_zero(a_out_zero), .out_count(a_out_count)
  );

  bit_wise_pipe #(.N(8), .STAGES(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_a(b_in_a), .in_b(b_in_b),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_c(b_out_c), .out_op(b_out_op),
    .out_zero(b_out_zero), .out_count(b_out_count)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return ~a;
    endcase
  endfunction

  typedef struct {
    logic [7:0] c;
    logic [2:0] op;
    int         t;
  } exp_t;

  exp_t        sq[$];
  exp_t        e, got;
  logic [31:0] r;
  logic [31:0] exp1 [8] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h0FFF_0FFF,
                            32'h000F_000F, 32'hF00F_F00F, 32'h00F0_00F0, 32'h0F0F_0F0F};
  logic [7:0]  pat = 8'b0110_1001;
  int          sent, recv, nouts;
  bit          hs_prev;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_op = 0; a_in_a = 0; a_in_b = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_op = 0; b_in_a = 0; b_in_b = 0; b_out_ready = 1;

    // Reset state
    #3;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_c", a_out_c, 0);
    chk("rst_out_op", a_out_op, 0);
    chk("rst_out_zero", a_out_zero, 0);
    chk("rst_out_count", a_out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", a_in_ready, 1);

    // All eight ops back-to-back, two cycles of latency each
    a_in_a = 32'hF0F0_F0F0;
    a_in_b = 32'hFF00_FF00;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 10) begin
        chk("t1_valid", a_out_valid, 1);
        chk("t1_c", a_out_c, exp1[k-2]);
        chk("t1_op", a_out_op, k - 2);
      end else begin
        chk("t1_idle", a_out_valid, 0);
      end
      if (k < 8) begin
        a_in_valid = 1;
        a_in_op = k[2:0];
      end else begin
        a_in_valid = 0;
      end
    end

    // Stall with three beats presented: two fit, third waits
    @(negedge clk);
    a_out_ready = 0; a_in_a = 32'h0000_00FF; a_in_b = 32'h0000_0F0F;
    a_in_valid = 1; a_in_op = 3'd0;
    #1 chk("t2_rdy_c1", a_in_ready, 1);
    @(negedge clk);
    chk("t2_notyet", a_out_valid, 0);
    a_in_op = 3'd1;
    #1 chk("t2_rdy_c2", a_in_ready, 1);
    @(negedge clk);
    a_in_op = 3'd2;
    #1 chk("t2_rdy_c3", a_in_ready, 0);
    chk("t2_stall_valid", a_out_valid, 1);
    chk("t2_stall_c", a_out_c, 32'h0000_000F);
    @(negedge clk);
    chk("t2_rdy_c4", a_in_ready, 0);
    chk("t2_hold_c", a_out_c, 32'h0000_000F);
    chk("t2_hold_op", a_out_op, 0);
    a_out_ready = 1;
    #1 chk("t2_rdy_release", a_in_ready, 1);
    @(negedge clk);
    chk("t2_beat2_c", a_out_c, 32'h0000_0FFF);
    chk("t2_beat2_op", a_out_op, 1);
    a_in_valid = 0;
    @(negedge clk);
    chk("t2_beat3_c", a_out_c, 32'h0000_0FF0);
    chk("t2_beat3_op", a_out_op, 2);
    @(negedge clk);
    chk("t2_drained", a_out_valid, 0);

    // Zero flag
    a_in_a = 32'hA5A5_A5A5; a_in_b = 32'hA5A5_A5A5;
    a_in_valid = 1; a_in_op = 3'd2;
    @(negedge clk);
    a_in_op = 3'd0;
    @(negedge clk);
    a_in_valid = 0;
    chk("t3_xor_valid", a_out_valid, 1);
    chk("t3_xor_c", a_out_c, 0);
    chk("t3_xor_zero", a_out_zero, 1);
    @(negedge clk);
    chk("t3_and_c", a_out_c, 32'hA5A5_A5A5);
    chk("t3_and_zero", a_out_zero, 0);

    // Reset with two beats in flight
    @(negedge clk);
    a_out_ready = 0; a_in_a = 32'h1; a_in_b = 32'h2; a_in_valid = 1; a_in_op = 3'd1;
    @(negedge clk);
    a_in_op = 3'd2;
    @(negedge clk);
    a_in_valid = 0;
    chk("t4_inflight", a_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_valid", a_out_valid, 0);
    chk("t4_async_c", a_out_c, 0);
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 1;
    #1 chk("t4_in_ready", a_in_ready, 1);
    chk("t4_count", a_out_count, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_no_ghost", a_out_valid, 0);
    end

    // Five output handshakes under a stall pattern
    sent = 0; recv = 0;
    a_in_a = 32'h0; a_in_b = 32'h0; a_in_op = 3'd7;
    for (int cyc = 0; cyc < 60 && recv < 5; cyc++) begin
      @(negedge clk);
      a_in_valid = (sent < 5);
      a_out_ready = pat[cyc % 8];
      #1;
      if (a_in_valid && a_in_ready) sent++;
      if (a_out_valid && a_out_ready) begin
        recv++;
        chk("t5_c", a_out_c, 32'hFFFF_FFFF);
      end
    end
    @(negedge clk);
    a_in_valid = 0;
    a_out_ready = 1;
    chk("t5_recv", recv, 5);
`ifdef BIT_WISE_PIPE_STATS_EN
    chk("t5_count5", a_out_count, 5);
    force dut_a.count_q = 32'hFFFF_FFFF;
    #1 release dut_a.count_q;
    chk("t5_preload", a_out_count, 32'hFFFF_FFFF);
    a_in_valid = 1;
    @(negedge clk);
    a_in_valid = 0;
    @(negedge clk);
    chk("t5_wrap_valid", a_out_valid, 1);
    @(negedge clk);
    chk("t5_wrap", a_out_count, 0);
`else
    chk("t5_count_tied", a_out_count, 0);
`endif

    // Wide pipe: latency 4 and full throughput
    b_out_ready = 1; nouts = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (cyc < 16) begin
        b_in_valid = 1; b_in_op = cyc[2:0];
        b_in_a = 8'($urandom); b_in_b = 8'($urandom);
      end else begin
        b_in_valid = 0;
      end
      #1;
      if (cyc < 16) chk("t6_thru_rdy", b_in_ready, 1);
      if (b_in_valid && b_in_ready) begin
        r = ref_fn(b_in_op, {24'h0, b_in_a}, {24'h0, b_in_b});
        e.c = r[7:0]; e.op = b_in_op; e.t = cyc;
        sq.push_back(e);
      end
      if (b_out_valid && b_out_ready) begin
        nouts++;
        if (sq.size() == 0) begin
          chk("t6_spurious", b_out_valid, 0);
        end else begin
          got = sq.pop_front();
          chk("t6_lat_c", b_out_c, got.c);
          chk("t6_lat_op", b_out_op, got.op);
          chk("t6_latency", cyc - got.t, 4);
        end
      end
    end
    chk("t6_thru_count", nouts, 16);

    // Wide pipe: random valid/ready traffic
    sent = 0; recv = 0; hs_prev = 0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      @(negedge clk);
      if (hs_prev) b_in_valid = 0;
      if (!b_in_valid && sent < 1000 && $urandom_range(3) != 0) begin
        b_in_valid = 1; b_in_op = 3'($urandom);
        b_in_a = 8'($urandom); b_in_b = 8'($urandom);
      end
      b_out_ready = ($urandom_range(2) != 0);
      #1;
      hs_prev = b_in_valid && b_in_ready;
      if (hs_prev) begin
        sent++;
        r = ref_fn(b_in_op, {24'h0, b_in_a}, {24'h0, b_in_b});
        e.c = r[7:0]; e.op = b_in_op; e.t = cyc;
        sq.push_back(e);
      end
      if (b_out_valid && b_out_ready) begin
        recv++;
        if (sq.size() == 0) begin
          chk("t7_spurious", b_out_valid, 0);
        end else begin
          got = sq.pop_front();
          chk("t7_c", b_out_c, got.c);
          chk("t7_op", b_out_op, got.op);
          chk("t7_zero", b_out_zero, got.c == 8'h0);
        end
      end
    end
    chk("t7_recv", recv, 1000);
    chk("t7_leftover", sq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
